// File: rtl/alu_pkg.sv
// alu_pkg: op codes, nibble count and FSM encoding shared by nibble_serial_alu and its slice.
package alu_pkg;
    localparam int NIBBLES = 8;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
    function automatic logic is_arith(input logic [2:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_SLT;
    endfunction
endpackage

// File: rtl/nibble_serial_alu_cla.sv
// cla_4bit: 4-bit ALU slice with carry lookahead; the bit-3 carry-in tap exists only
// when SERIAL_ALU_OVERFLOW_EN is defined.
module cla_4bit
    import alu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [2:0] op_i,
    input  logic       cin_i,
    input  logic       less_i,
    output logic [3:0] y_o,
    output logic       cout_o
`ifdef SERIAL_ALU_OVERFLOW_EN
    ,
    output logic       c3_o
`endif
);
    logic [3:0] bb, g, p, sum;
    logic [4:0] c;
    always_comb begin
        bb   = (op_i == OP_SUB) ? ~b_i : b_i;
        g    = a_i & bb;
        p    = a_i ^ bb;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        y_o  = (op_i == OP_AND) ? a_i & b_i :
               (op_i == OP_OR)  ? a_i | b_i :
               (op_i == OP_XOR) ? a_i ^ b_i :
               (op_i == OP_NOR) ? ~(a_i | b_i) :
               (op_i == OP_ADD || op_i == OP_SUB) ? sum :
               (op_i == OP_SLT) ? {3'b000, less_i} : 4'h0;
    end
    assign cout_o = c[4];
`ifdef SERIAL_ALU_OVERFLOW_EN
    assign c3_o = c[3];
`endif
endmodule

// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: 32-bit ALU evaluated one nibble per cycle through a single cla_4bit.
// SERIAL_ALU_OVERFLOW_EN enables signed overflow and the overflow-corrected SLT.
module nibble_serial_alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        overflow,
    output logic        zero
);
    state_t      state_q;
    logic [2:0]  idx_q, op_q;
    logic [31:0] a_q, b_q, result_q, res_d;
    logic [27:0] acc_q;
    logic        cy_q, carry_q, ov_q, zero_q;
    logic [2:0]  slice_op;
    logic [3:0]  y;
    logic        slice_cin, cout, ov_d, carry_d;
`ifdef SERIAL_ALU_OVERFLOW_EN
    logic        c3;
`endif
    cla_4bit u_slice (
        .a_i    (a_q[3:0]),
        .b_i    (b_q[3:0]),
        .op_i   (slice_op),
        .cin_i  (slice_cin),
        .less_i (1'b0),
        .y_o    (y),
        .cout_o (cout)
`ifdef SERIAL_ALU_OVERFLOW_EN
        ,
        .c3_o   (c3)
`endif
    );
    always_comb begin
        slice_op  = (op_q == OP_SLT) ? OP_SUB : op_q;
        slice_cin = (idx_q == 3'd0) ? (op_q == OP_SUB || op_q == OP_SLT) : cy_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
        ov_d      = is_arith(op_q) & (c3 ^ cout);
`else
        ov_d      = 1'b0;
`endif
        carry_d   = is_arith(op_q) & cout;
        res_d     = (op_q == OP_SLT) ? {31'b0, y[3] ^ ov_d} : {y, acc_q};
    end
    // Operands shift right so the active nibble is always at bits 3:0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ov_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    op_q    <= op;
                    idx_q   <= '0;
                    cy_q    <= 1'b0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    acc_q <= {y, acc_q[27:4]};
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    cy_q  <= cout;
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'(NIBBLES - 1)) begin
                        result_q <= res_d;
                        carry_q  <= carry_d;
                        ov_q     <= ov_d;
                        zero_q   <= (res_d == '0);
                        state_q  <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ov_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb_nibble_serial_alu: directed and random operations checked against a 32-bit arithmetic model.
module tb_nibble_serial_alu;
`ifdef SERIAL_ALU_OVERFLOW_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst, start;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        busy, done, carry_out, overflow, zero;
    int          ncmp = 0, nfail = 0;

    nibble_serial_alu dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic cy, output logic ov);
        logic [32:0] s;
        logic        v;
        s = '0; v = 1'b0; r = '0; cy = 1'b0;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b011: r = x ^ y;
            3'b100: r = ~(x | y);
            3'b010: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[31:0];
                cy = s[32];
                v  = (x[31] == y[31]) && (s[31] != x[31]);
            end
            3'b110, 3'b111: begin
                s  = {1'b0, x} + {1'b0, ~y} + 33'd1;
                cy = s[32];
                v  = (x[31] != y[31]) && (s[31] != x[31]);
                r  = (o == 3'b110) ? s[31:0] :
                     OV_EN ? {31'b0, $signed(x) < $signed(y)} : {31'b0, s[31]};
            end
            default: r = '0;
        endcase
        ov = v & OV_EN;
    endtask

    // Presents start in the current cycle (cycle 0) and checks through cycle 10.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit noisy);
        logic [31:0] er;
        logic        ec, ev;
        model(o, x, y, er, ec, ev);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            start = noisy && (c == 3 || c == 5);
            if (start) begin
                a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
            end
            chk($sformatf("busy_done_c%0d", c), {30'b0, busy, done}, 32'd2);
            tick();
        end
        start = 1'b0;
        chk("done_c9", {30'b0, busy, done}, 32'd3);
        chk($sformatf("result op%0d", o), result, er);
        chk("carry_out", {31'b0, carry_out}, {31'b0, ec});
        chk("overflow", {31'b0, overflow}, {31'b0, ev});
        chk("zero", {31'b0, zero}, {31'b0, er == 32'd0});
        tick();
        chk("idle_c10", {30'b0, busy, done}, 32'd0);
        chk("result_held", result, er);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        tick(); tick();
        chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'b0, carry_out, overflow, zero}, 32'd0);
        rst = 1'b0;
        tick();
        run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(3'b110, 32'd5, 32'd7, 1'b0);
        run_op(3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b111, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        run_op(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        run_op(3'b010, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op(3'b010, 32'd1, 32'd2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("no_second_op", {30'b0, busy, done}, 32'd0);
            chk("noisy_result_held", result, 32'd3);
            tick();
        end
        op = 3'b010; a = 32'd1; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy_done", {30'b0, busy, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_flags", {29'b0, carry_out, overflow, zero}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("abort_no_done", {30'b0, busy, done}, 32'd0);
            tick();
        end
        run_op(3'b100, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0);
        for (int k = 0; k < 40; k++)
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
